// File: rtl/apb_sram_slave.sv
// APB4 memory slave: parametrised depth, base address and wait states, byte-strobe
// writes, registered read data and PSLVERR on out-of-range or misaligned accesses.
module apb_sram_slave #(
    parameter logic [31:0] ADDR_BASE   = 32'h1000_0000,
    parameter int unsigned DEPTH_LOG2  = 4,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [31:0] PADDR,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  PSTRB,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [31:0] SPAN     = 32'(DEPTH) << 2;
    localparam logic [3:0]  CNT_INIT = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;

    logic [DEPTH_LOG2-1:0] idx_q;
    logic                  write_q;
    logic [31:0]           wdata_q;
    logic [3:0]            strb_q;
    logic                  err_q;

    logic [31:0]           prdata_q;
    logic                  pslverr_q;
    logic [31:0]           mem_q [DEPTH];

    logic                  setup;
    logic [31:0]           offset;
    logic                  in_err;
    logic [DEPTH_LOG2-1:0] in_idx;

    logic                  cur_write;
    logic                  cur_err;
    logic [DEPTH_LOG2-1:0] cur_idx;
    logic [31:0]           cur_wdata;
    logic [3:0]            cur_strb;
    logic                  commit;
    logic                  mem_we;

    assign setup  = PSEL && !PENABLE;
    assign offset = PADDR - ADDR_BASE;
    assign in_err = (offset >= SPAN) || (PADDR[1:0] != 2'b00);
    assign in_idx = offset[DEPTH_LOG2+1:2];

    // With zero wait states the commit edge is the setup edge itself, so the
    // transfer attributes come straight from the bus while still in IDLE.
    always_comb begin
        if (state_q == S_IDLE) begin
            cur_write = PWRITE;
            cur_err   = in_err;
            cur_idx   = in_idx;
            cur_wdata = PWDATA;
            cur_strb  = PSTRB;
        end else begin
            cur_write = write_q;
            cur_err   = err_q;
            cur_idx   = idx_q;
            cur_wdata = wdata_q;
            cur_strb  = strb_q;
        end
    end

    assign commit = !PRESET && (state_d == S_RESP) && (state_q != S_RESP);
    assign mem_we = commit && cur_write && !cur_err;

    // State register
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (setup) begin
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (!PSEL) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Setup-phase capture; these are qualified by the FSM and need no reset.
    always_ff @(posedge PCLK) begin
        if (state_q == S_IDLE && setup) begin
            idx_q   <= in_idx;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
            err_q   <= in_err;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            prdata_q  <= 32'd0;
            pslverr_q <= 1'b0;
        end else if (commit) begin
            prdata_q  <= (cur_err || cur_write) ? 32'd0 : mem_q[cur_idx];
            pslverr_q <= cur_err;
        end else begin
            prdata_q  <= 32'd0;
            pslverr_q <= 1'b0;
        end
    end

    // NOTE: the array has no reset branch so it maps onto plain RAM; its
    // contents survive PRESET and are undefined after power-up.
    always_ff @(posedge PCLK) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_strb[i]) begin
                    mem_q[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
                end
            end
        end
    end

    // Output logic
    always_comb begin
        PREADY  = (state_q == S_RESP);
        PSLVERR = pslverr_q;
        PRDATA  = prdata_q;
    end

endmodule

// File: tb/tb_apb_sram_slave.sv
// Directed bench for apb_sram_slave: three instances (0, 2 and 3 wait states)
// share one APB bus and are addressed through separate PSEL lines.
module tb_apb_sram_slave;

    logic        PCLK;
    logic        PRESET;
    logic [31:0] PADDR;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [3:0]  psel;
    logic [31:0] prdata [4];
    logic [3:0]  pready;
    logic [3:0]  pslverr;

    int checks = 0;
    int errors = 0;

    apb_sram_slave #(.ADDR_BASE(32'h1000_0000), .DEPTH_LOG2(4), .WAIT_STATES(0)) u_dut0 (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(psel[0]), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
    );

    apb_sram_slave #(.ADDR_BASE(32'h1000_0000), .DEPTH_LOG2(4), .WAIT_STATES(2)) u_dut2 (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(psel[2]), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2])
    );

    apb_sram_slave #(.ADDR_BASE(32'h1000_0000), .DEPTH_LOG2(4), .WAIT_STATES(3)) u_dut3 (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(psel[3]), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(prdata[3]), .PREADY(pready[3]), .PSLVERR(pslverr[3])
    );

    assign prdata[1]  = 32'd0;
    assign pready[1]  = 1'b0;
    assign pslverr[1] = 1'b0;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // One APB transfer on instance d. Inputs are driven on the falling edge;
    // the address and data are scrambled in the access phase, which the slave
    // must ignore. Returns in the middle of the PREADY cycle.
    task automatic xfer(input int d, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        output logic [31:0] rdata, output logic err, output int cycles);
        @(negedge PCLK);
        psel    = 4'b0;
        psel[d] = 1'b1;
        PENABLE = 1'b0;
        PADDR   = addr;
        PWRITE  = wr;
        PWDATA  = wdata;
        PSTRB   = strb;
        cycles  = 1;
        @(negedge PCLK);
        PENABLE = 1'b1;
        PADDR   = ~addr;
        PWDATA  = ~wdata;
        PSTRB   = ~strb;
        cycles  = 2;
        while (pready[d] !== 1'b1 && cycles < 40) begin
            @(negedge PCLK);
            cycles++;
        end
        checks++;
        if (pready[d] !== 1'b1) begin
            errors++;
            $display("FAIL xfer_timeout: dut %0d addr %h no PREADY after %0d cycles", d, addr, cycles);
        end
        rdata = prdata[d];
        err   = pslverr[d];
    endtask

    task automatic bus_idle();
        @(negedge PCLK);
        psel    = 4'b0;
        PENABLE = 1'b0;
    endtask

    // Setup plus one access cycle on instance d, then PRESET for ncyc cycles.
    task automatic start_then_reset(input int d, input logic [31:0] addr, input logic wr,
                                    input logic [31:0] wdata, input int ncyc);
        @(negedge PCLK);
        psel    = 4'b0;
        psel[d] = 1'b1;
        PENABLE = 1'b0;
        PADDR   = addr;
        PWRITE  = wr;
        PWDATA  = wdata;
        PSTRB   = 4'hF;
        @(negedge PCLK);
        PENABLE = 1'b1;
        PRESET  = 1'b1;
        repeat (ncyc) @(negedge PCLK);
        PRESET  = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic        er;
        int          cyc;
        bit          seen;
        PRESET = 1'b1;
        repeat (2) @(negedge PCLK);
        for (int d = 0; d < 4; d += 2) begin
            if (d == 2) d = 2;
            checks++;
            if (pready[d] !== 1'b0 || pslverr[d] !== 1'b0 || prdata[d] !== 32'd0) begin
                errors++;
                $display("FAIL reset_init dut%0d: got rdy %b err %b data %h expected 0 0 0",
                         d, pready[d], pslverr[d], prdata[d]);
            end
        end
        checks++;
        if (pready[3] !== 1'b0 || pslverr[3] !== 1'b0 || prdata[3] !== 32'd0) begin
            errors++;
            $display("FAIL reset_init dut3: got rdy %b err %b data %h expected 0 0 0",
                     pready[3], pslverr[3], prdata[3]);
        end
        PRESET = 1'b0;

        xfer(3, 32'h1000_0004, 1'b1, 32'h1234_5678, 4'hF, rd, er, cyc);
        checks++;
        if (cyc !== 5) begin
            errors++;
            $display("FAIL reset_ws3_cycles: got %0d expected %0d", cyc, 5);
        end

        // Reset held for 2 cycles in the middle of a read.
        start_then_reset(3, 32'h1000_0004, 1'b0, 32'd0, 2);
        checks++;
        if (pready[3] !== 1'b0 || pslverr[3] !== 1'b0 || prdata[3] !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_read: got rdy %b err %b data %h expected 0 0 0",
                     pready[3], pslverr[3], prdata[3]);
        end
        psel    = 4'b0;
        PENABLE = 1'b0;
        seen    = 1'b0;
        repeat (6) begin
            @(negedge PCLK);
            if (pready[3] === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_no_late_pready: got PREADY pulse expected none");
        end

        // Reset in the middle of a write: the write must be lost.
        start_then_reset(3, 32'h1000_0004, 1'b1, 32'h9999_9999, 1);
        bus_idle();
        xfer(3, 32'h1000_0004, 1'b0, 32'd0, 4'h0, rd, er, cyc);
        checks++;
        if (rd !== 32'h1234_5678 || er !== 1'b0 || cyc !== 5) begin
            errors++;
            $display("FAIL reset_after_read: got data %h err %b cyc %0d expected 12345678 0 5",
                     rd, er, cyc);
        end
        bus_idle();
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd;
        logic        er;
        int          cyc;
        xfer(0, 32'h1000_0008, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, er, cyc);
        checks++;
        if (cyc !== 2 || er !== 1'b0 || rd !== 32'd0) begin
            errors++;
            $display("FAIL zw_write: got cyc %0d err %b data %h expected 2 0 00000000", cyc, er, rd);
        end
        xfer(0, 32'h1000_0008, 1'b0, 32'd0, 4'h0, rd, er, cyc);
        checks++;
        if (cyc !== 2 || er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL zw_read: got cyc %0d err %b data %h expected 2 0 deadbeef", cyc, er, rd);
        end
        bus_idle();
        checks++;
        if (pready[0] !== 1'b0 || prdata[0] !== 32'd0) begin
            errors++;
            $display("FAIL zw_pready_one_cycle: got rdy %b data %h expected 0 00000000",
                     pready[0], prdata[0]);
        end
    endtask

    task automatic test_strobes();
        logic [31:0] rd;
        logic        er;
        int          cyc;
        xfer(0, 32'h1000_000C, 1'b1, 32'h1122_3344, 4'hF, rd, er, cyc);
        xfer(0, 32'h1000_000C, 1'b1, 32'hAABB_CCDD, 4'b0101, rd, er, cyc);
        xfer(0, 32'h1000_000C, 1'b0, 32'd0, 4'h0, rd, er, cyc);
        checks++;
        if (rd !== 32'h11BB_33DD) begin
            errors++;
            $display("FAIL strb_0101: got %h expected %h", rd, 32'h11BB_33DD);
        end
        xfer(0, 32'h1000_000C, 1'b1, 32'hFFFF_FFFF, 4'b0000, rd, er, cyc);
        checks++;
        if (er !== 1'b0 || cyc !== 2) begin
            errors++;
            $display("FAIL strb_zero_resp: got err %b cyc %0d expected 0 2", er, cyc);
        end
        xfer(0, 32'h1000_000C, 1'b0, 32'd0, 4'h0, rd, er, cyc);
        checks++;
        if (rd !== 32'h11BB_33DD) begin
            errors++;
            $display("FAIL strb_zero_noop: got %h expected %h", rd, 32'h11BB_33DD);
        end
        bus_idle();
    endtask

    task automatic test_wait_states();
        logic [31:0] rd;
        logic        er;
        int          cyc;
        bit          seen;
        xfer(2, 32'h1000_0000, 1'b1, 32'hCAFE_0001, 4'hF, rd, er, cyc);
        xfer(2, 32'h1000_0000, 1'b0, 32'd0, 4'h0, rd, er, cyc);
        checks++;
        if (cyc !== 4 || rd !== 32'hCAFE_0001 || er !== 1'b0) begin
            errors++;
            $display("FAIL ws2_read: got cyc %0d data %h err %b expected 4 cafe0001 0", cyc, rd, er);
        end
        bus_idle();
        checks++;
        if (pready[2] !== 1'b0) begin
            errors++;
            $display("FAIL ws2_pready_one_cycle: got %b expected 0", pready[2]);
        end

        // Abort: PSEL dropped in the first access cycle.
        @(negedge PCLK);
        psel[2] = 1'b1;
        PENABLE = 1'b0;
        PADDR   = 32'h1000_0000;
        PWRITE  = 1'b1;
        PWDATA  = 32'h5555_5555;
        PSTRB   = 4'hF;
        @(negedge PCLK);
        psel[2] = 1'b0;
        PENABLE = 1'b1;
        seen    = 1'b0;
        repeat (5) begin
            @(negedge PCLK);
            PENABLE = 1'b0;
            if (pready[2] === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL ws2_abort_pready: got PREADY pulse expected none");
        end
        xfer(2, 32'h1000_0000, 1'b0, 32'd0, 4'h0, rd, er, cyc);
        checks++;
        if (rd !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL ws2_abort_nowrite: got %h expected %h", rd, 32'hCAFE_0001);
        end
        bus_idle();
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er;
        int          cyc;
        xfer(0, 32'h1000_0000, 1'b1, 32'h0000_AAAA, 4'hF, rd, er, cyc);
        xfer(0, 32'h1000_003C, 1'b1, 32'h0000_BBBB, 4'hF, rd, er, cyc);

        xfer(0, 32'h1000_0040, 1'b1, 32'h7777_7777, 4'hF, rd, er, cyc);
        checks++;
        if (er !== 1'b1 || cyc !== 2 || rd !== 32'd0) begin
            errors++;
            $display("FAIL err_past_end: got err %b cyc %0d data %h expected 1 2 00000000", er, cyc, rd);
        end
        bus_idle();
        checks++;
        if (pslverr[0] !== 1'b0 || pready[0] !== 1'b0) begin
            errors++;
            $display("FAIL err_one_cycle: got err %b rdy %b expected 0 0", pslverr[0], pready[0]);
        end

        xfer(0, 32'h0FFF_FFFC, 1'b0, 32'd0, 4'h0, rd, er, cyc);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL err_below_base: got err %b data %h expected 1 00000000", er, rd);
        end

        xfer(0, 32'h1000_0002, 1'b1, 32'h6666_6666, 4'hF, rd, er, cyc);
        checks++;
        if (er !== 1'b1) begin
            errors++;
            $display("FAIL err_misaligned_wr: got err %b expected 1", er);
        end
        xfer(0, 32'h1000_0002, 1'b0, 32'd0, 4'h0, rd, er, cyc);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL err_misaligned_rd: got err %b data %h expected 1 00000000", er, rd);
        end

        xfer(0, 32'h1000_0000, 1'b0, 32'd0, 4'h0, rd, er, cyc);
        checks++;
        if (rd !== 32'h0000_AAAA || er !== 1'b0) begin
            errors++;
            $display("FAIL err_word0_intact: got %h err %b expected 0000aaaa 0", rd, er);
        end
        xfer(0, 32'h1000_003C, 1'b0, 32'd0, 4'h0, rd, er, cyc);
        checks++;
        if (rd !== 32'h0000_BBBB || er !== 1'b0) begin
            errors++;
            $display("FAIL err_word15_intact: got %h err %b expected 0000bbbb 0", rd, er);
        end
        bus_idle();
    endtask

    task automatic test_back_to_back(input int d);
        logic [31:0] rd;
        logic        er;
        int          cyc;
        int          exp_cyc;
        int          bad_cyc;
        int          bad_data;
        exp_cyc = (d == 0) ? 2 : 4;
        xfer(d, 32'h1000_003C, 1'b1, 32'hF00D_F00D, 4'hF, rd, er, cyc);
        xfer(d, 32'h1000_003C, 1'b0, 32'd0, 4'h0, rd, er, cyc);
        checks++;
        if (rd !== 32'hF00D_F00D || er !== 1'b0) begin
            errors++;
            $display("FAIL b2b_last_word dut%0d: got %h err %b expected f00df00d 0", d, rd, er);
        end
        bad_cyc  = 0;
        bad_data = 0;
        for (int i = 0; i < 16; i++) begin
            xfer(d, 32'h1000_0000 + 32'(4 * i), 1'b1, 32'(i), 4'hF, rd, er, cyc);
            if (cyc != exp_cyc || er !== 1'b0) bad_cyc++;
        end
        for (int i = 0; i < 16; i++) begin
            xfer(d, 32'h1000_0000 + 32'(4 * i), 1'b0, 32'd0, 4'h0, rd, er, cyc);
            if (cyc != exp_cyc || er !== 1'b0) bad_cyc++;
            checks++;
            if (rd !== 32'(i)) begin
                errors++;
                bad_data++;
                $display("FAIL b2b_read dut%0d idx %0d: got %h expected %h", d, i, rd, 32'(i));
            end
        end
        checks++;
        if (bad_cyc != 0) begin
            errors++;
            $display("FAIL b2b_timing dut%0d: got %0d transfers off %0d cycles expected 0",
                     d, bad_cyc, exp_cyc);
        end
        bus_idle();
    endtask

    initial begin
        PRESET  = 1'b1;
        psel    = 4'b0;
        PENABLE = 1'b0;
        PADDR   = 32'd0;
        PWRITE  = 1'b0;
        PWDATA  = 32'd0;
        PSTRB   = 4'h0;
        test_reset();
        test_zero_wait();
        test_strobes();
        test_wait_states();
        test_errors();
        test_back_to_back(0);
        test_back_to_back(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
